// File: rtl/miniRISC_wb_pkg.sv
// Shared encodings for the miniRISC writeback stage and register-file write select.
package miniRISC_wb_pkg;

  localparam logic [1:0] WB_SRC_NONE = 2'b00;
  localparam logic [1:0] WB_SRC_ALU  = 2'b01;
  localparam logic [1:0] WB_SRC_MEM  = 2'b10;
  localparam logic [1:0] WB_SRC_LINK = 2'b11;

  localparam logic [1:0] WB_DEST_NONE = 2'b00;
  localparam logic [1:0] WB_DEST_R31  = 2'b01;
  localparam logic [1:0] WB_DEST_REG1 = 2'b10;
  localparam logic [1:0] WB_DEST_REG2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_COMMIT   = 2'b10
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Load-wait cycle counter; o_expire flags the last counted WAIT_MEM cycle.
module wb_timeout_counter #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear)
      r_cnt <= '0;
    else if (i_enable)
      r_cnt <= r_cnt + TO_W'(1);
  end

  assign o_expire = (r_cnt == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_unit.sv
// miniRISC writeback stage: selects ALU/load/link result and issues a one-cycle
// register-file commit, abandoning loads that exceed MEM_TIMEOUT wait cycles.
module writeback_unit
  import miniRISC_wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [1:0]        wb_src,
  input  logic [1:0]        wb_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [1:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              wb_done,
  output logic              mem_err
);

  wb_state_t         r_state;
  wb_state_t         w_next;
  logic [1:0]        r_src;
  logic [1:0]        r_dest;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              w_accept;
  logic              w_expire;
  logic              w_wait;
  logic              w_timeout;
  logic              w_cnt_en;

  assign w_accept  = wb_valid && (r_state == ST_IDLE);
  assign w_wait    = (r_state == ST_WAIT_MEM);
  // rvalid in the final counted cycle takes priority over the timeout
  assign w_timeout = w_wait && !mem_rvalid && w_expire;
  assign w_cnt_en  = w_wait && !mem_rvalid && !w_expire;

  wb_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_enable(w_cnt_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = (wb_src == WB_SRC_MEM) ? ST_WAIT_MEM : ST_COMMIT;
      ST_WAIT_MEM: if (mem_rvalid || w_expire) w_next = ST_COMMIT;
      ST_COMMIT:   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_src  <= wb_src;
      r_dest <= wb_dest;
    end else if (w_timeout) begin
      r_dest <= WB_DEST_NONE;
    end
  end

  // r_data doubles as the writeData register, so it holds between commits
  always_ff @(posedge clk) begin
    if (rst)
      r_data <= '0;
    else if (w_accept && (wb_src == WB_SRC_ALU))
      r_data <= alu_result;
    else if (w_accept && (wb_src == WB_SRC_LINK))
      r_data <= pc_plus1;
    else if (w_wait && mem_rvalid)
      r_data <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_timeout)
      r_err <= 1'b1;
  end

  assign wb_ready  = (r_state == ST_IDLE);
  assign wb_done   = (r_state == ST_COMMIT);
  assign writeReg  = ((r_state == ST_COMMIT) && (r_src != WB_SRC_NONE)) ? r_dest : WB_DEST_NONE;
  assign writeData = r_data;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a commit scoreboard.
module tb_writeback_unit;

  localparam int DATA_W      = 32;
  localparam int MEM_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_src;
  logic [1:0]        wb_dest;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_plus1;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [1:0]        writeReg;
  logic [DATA_W-1:0] writeData;
  logic              wb_done;
  logic              mem_err;

  typedef struct packed {
    logic [1:0]  wreg;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rf_r31 = '0;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_W     (DATA_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_src    (wb_src),
    .wb_dest   (wb_dest),
    .alu_result(alu_result),
    .pc_plus1  (pc_plus1),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .writeReg  (writeReg),
    .writeData (writeData),
    .wb_done   (wb_done),
    .mem_err   (mem_err)
  );

  // Register-file r31 as seen by the downstream register file
  always @(negedge clk) begin
    if (writeReg == 2'b01)
      rf_r31 <= writeData;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] src, input logic [1:0] dest,
                      input logic [31:0] alu, input logic [31:0] pc);
    chk("ready_before_accept", {31'b0, wb_ready}, 32'd1);
    wb_valid   = 1'b1;
    wb_src     = src;
    wb_dest    = dest;
    alu_result = alu;
    pc_plus1   = pc;
    step();
    wb_valid   = 1'b0;
    alu_result = 32'hBAD0_BAD0;
    pc_plus1   = 32'hBAD1_BAD1;
  endtask

  task automatic push(input logic [1:0] wreg, input logic [31:0] data);
    exp_t e;
    e.wreg = wreg;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_commit(input string tag, input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (!wb_done && n < budget) begin
      chk({tag, "_wreg_idle"}, {30'b0, writeReg}, 32'd0);
      step();
      n++;
    end
    if (!wb_done) begin
      chk({tag, "_commit_timeout"}, {31'b0, wb_done}, 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_commit"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wreg"}, {30'b0, writeReg}, {30'b0, e.wreg});
      chk({tag, "_wdata"}, writeData, e.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    wb_valid   = 1'b0;
    wb_src     = 2'b00;
    wb_dest    = 2'b00;
    alu_result = '0;
    pc_plus1   = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    step();
    step();
    chk("rst_ready", {31'b0, wb_ready}, 32'd1);
    chk("rst_wreg", {30'b0, writeReg}, 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_done", {31'b0, wb_done}, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    rst = 1'b0;
    step();

    // ALU write: commit visible the cycle after accept
    push(2'b10, 32'h0000_002A);
    send(2'b01, 2'b10, 32'h0000_002A, 32'h0);
    chk("alu_done", {31'b0, wb_done}, 32'd1);
    wait_commit("alu", 0);
    step();
    chk("alu_after_wreg", {30'b0, writeReg}, 32'd0);
    chk("alu_after_ready", {31'b0, wb_ready}, 32'd1);
    chk("alu_after_done", {31'b0, wb_done}, 32'd0);
    chk("alu_hold_wdata", writeData, 32'h0000_002A);

    // Link write to r31
    push(2'b01, 32'h0000_0105);
    send(2'b11, 2'b01, 32'h0, 32'h0000_0105);
    wait_commit("link", 0);
    step();
    chk("link_r31", rf_r31, 32'h0000_0105);
    chk("link_single_commit", {31'b0, wb_done}, 32'd0);

    // src=NONE: pulse done, no write, data holds
    push(2'b00, 32'h0000_0105);
    send(2'b00, 2'b10, 32'h1234_5678, 32'h0);
    wait_commit("none", 0);
    step();

    // Load arriving in the third WAIT_MEM cycle; rvalid in the accept cycle is ignored
    push(2'b11, 32'hDEAD_BEEF);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    send(2'b10, 2'b11, 32'h0, 32'h0);
    mem_rvalid = 1'b0;
    chk("load_ready0_a", {31'b0, wb_ready}, 32'd0);
    step();
    chk("load_ready0_b", {31'b0, wb_ready}, 32'd0);
    step();
    chk("load_ready0_c", {31'b0, wb_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    wait_commit("load", 0);
    chk("load_err", {31'b0, mem_err}, 32'd0);
    step();

    // Boundary: rvalid in the last counted WAIT_MEM cycle wins
    push(2'b10, 32'h0000_0001);
    send(2'b10, 2'b10, 32'h0, 32'h0);
    step();
    step();
    step();
    chk("bound_still_waiting", {31'b0, wb_done}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0001;
    step();
    mem_rvalid = 1'b0;
    wait_commit("bound", 0);
    chk("bound_err", {31'b0, mem_err}, 32'd0);
    step();

    // Timeout: no rvalid, commit with no write and sticky error
    push(2'b00, 32'h0000_0001);
    send(2'b10, 2'b10, 32'h0, 32'h0);
    wait_commit("tmo", 8);
    chk("tmo_done", {31'b0, wb_done}, 32'd1);
    chk("tmo_err", {31'b0, mem_err}, 32'd1);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    chk("tmo_late_done", {31'b0, wb_done}, 32'd0);
    chk("tmo_late_wreg", {30'b0, writeReg}, 32'd0);
    chk("tmo_late_wdata", writeData, 32'h0000_0001);
    chk("tmo_err_sticky", {31'b0, mem_err}, 32'd1);
    step();

    // Reset while in WAIT_MEM drops the request
    send(2'b10, 2'b11, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_ready", {31'b0, wb_ready}, 32'd1);
    chk("rstmid_wreg", {30'b0, writeReg}, 32'd0);
    chk("rstmid_done", {31'b0, wb_done}, 32'd0);
    chk("rstmid_err_clr", {31'b0, mem_err}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0077;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_commit", {31'b0, wb_done}, 32'd0);
      chk("rstmid_no_write", {30'b0, writeReg}, 32'd0);
      step();
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
